imem_loader: RTL

Program loader and instruction store for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake and assembles 12-bit instruction words into a 16-entry instruction memory. It validates the stream with a length header and an XOR checksum, then releases the core through `cpu_run`. The core's fetch path reads the same storage combinationally through `fetch_addr`/`fetch_instr`, so this block replaces the hard-coded instruction array with a writable one.

---
 rtl/imem_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader feeding a writable 16 x 12-bit
// instruction store. Validates a length header and XOR checksum, then
// releases the core via cpu_run. The fetch port reads the store combinationally.
module imem_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned IW    = 12
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_instr,
  output logic          cpu_run,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LO,
    S_HI,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   wl_q, wl_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    lo_q, lo_d;
  logic          cpu_run_q, load_err_q;
  logic          mem_we;
  logic [IW-1:0] mem_wdata;
  logic          accept;
  logic [IW-1:0] mem_q [DEPTH];

  // Next-state, datapath updates and handshake decode
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    n_d       = n_q;
    wl_d      = wl_q;
    csum_d    = csum_q;
    lo_d      = lo_q;
    mem_we    = 1'b0;
    mem_wdata = IW'({in_data[3:0], lo_q});
    in_ready  = ((state_q == S_HDR) || (state_q == S_LO) ||
                 (state_q == S_HI)  || (state_q == S_CSUM)) && !reload;
    accept    = in_valid && in_ready;

    if (reload) begin
      // Reload wins over any offered byte; memory contents are kept
      state_d = S_HDR;
      wptr_d  = '0;
      csum_d  = '0;
      wl_d    = '0;
    end else if (accept) begin
      case (state_q)
        S_HDR: begin
          if ((in_data == 8'd0) || (32'(in_data) > DEPTH)) begin
            state_d = S_ERR;
          end else begin
            n_d     = (AW+1)'(in_data);
            wptr_d  = '0;
            csum_d  = in_data;
            state_d = S_LO;
          end
        end
        S_LO: begin
          lo_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = S_HI;
        end
        S_HI: begin
          mem_we = 1'b1;
          csum_d = csum_q ^ in_data;
          if (wl_q < n_q) begin
            wl_d = wl_q + (AW+1)'(1);
          end
          if ((AW+1)'(wptr_q) == (n_q - (AW+1)'(1))) begin
            state_d = S_CSUM;
          end else begin
            wptr_d  = wptr_q + AW'(1);
            state_d = S_LO;
          end
        end
        S_CSUM: begin
          state_d = (in_data == csum_q) ? S_RUN : S_ERR;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_HDR;
      wptr_q     <= '0;
      n_q        <= '0;
      wl_q       <= '0;
      csum_q     <= '0;
      lo_q       <= '0;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      n_q        <= n_d;
      wl_q       <= wl_d;
      csum_q     <= csum_d;
      lo_q       <= lo_d;
      cpu_run_q  <= (state_d == S_RUN);
      load_err_q <= (state_d == S_ERR);
    end
  end

  // Instruction store; cleared only by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wptr_q] <= mem_wdata;
    end
  end

  assign fetch_instr  = mem_q[fetch_addr];
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = wl_q;

endmodule
